// File: rtl/ac_match_sequencer.sv
// Aho-Corasick table-walk sequencer: 3 cycles per char on a goto hit, +2 per failure hop; EN low freezes, CHAR_READY only in IDLE.
// AC_MATCH_COUNT_EN adds a saturating MATCH_COUNT; otherwise MATCH_COUNT is tied to 0.
module ac_match_sequencer #(
   parameter int STATE_W  = 8,
   parameter int CHAR_W   = 4,
   parameter int MAX_FAIL = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               CLR,
   input  logic               CHAR_VALID,
   input  logic [CHAR_W-1:0]  CHAR_IN,
   output logic               CHAR_READY,
   output logic               TBL_RD,
   output logic [STATE_W-1:0] TBL_ADDR,
   input  logic [CHAR_W-1:0]  TBL_CHARA,
   input  logic [STATE_W-1:0] TBL_NEXT,
   input  logic [STATE_W-1:0] TBL_FAIL,
   input  logic               TBL_ACCEPT,
   output logic [STATE_W-1:0] CUR_STATE,
   output logic               BUSY,
   output logic               MATCH_VALID,
   output logic [STATE_W-1:0] MATCH_STATE,
   output logic               ERR_LOOP,
   output logic [15:0]        MATCH_COUNT
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_EVAL   = 2'd2;
   localparam logic [7:0] FAIL_LIM = 8'(MAX_FAIL);

   logic [1:0]         fsm;
   logic [STATE_W-1:0] work_state;
   logic [STATE_W-1:0] cur_state;
   logic [7:0]         fail_cnt;
   logic [CHAR_W-1:0]  char_q;
   logic               match_valid_q;
   logic [STATE_W-1:0] match_state_q;
   logic               err_loop_q;

   logic accept;
   logic hit;
   logic last_hop;
   logic match_commit;

   // A handshake is never offered while RST/CLR would discard it.
   assign CHAR_READY   = (fsm == S_IDLE) & EN & ~RST & ~CLR;
   assign accept       = CHAR_VALID & CHAR_READY;
   assign TBL_RD       = (fsm == S_LOOKUP) & EN & ~RST & ~CLR;
   assign TBL_ADDR     = work_state;
   assign BUSY         = (fsm != S_IDLE);
   assign hit          = (TBL_CHARA == char_q);
   assign last_hop     = ((fail_cnt + 8'd1) == FAIL_LIM);
   assign match_commit = EN & ~RST & ~CLR & (fsm == S_EVAL) & hit & TBL_ACCEPT;

   assign CUR_STATE   = cur_state;
   assign MATCH_VALID = match_valid_q;
   assign MATCH_STATE = match_state_q;
   assign ERR_LOOP    = err_loop_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         fsm           <= S_IDLE;
         work_state    <= '0;
         cur_state     <= '0;
         fail_cnt      <= '0;
         char_q        <= '0;
         match_valid_q <= 1'b0;
         match_state_q <= '0;
         err_loop_q    <= 1'b0;
      end else if (CLR) begin
         fsm           <= S_IDLE;
         work_state    <= '0;
         cur_state     <= '0;
         match_valid_q <= 1'b0;
      end else begin
         // MATCH_VALID is a pulse even if EN drops right after the commit.
         match_valid_q <= 1'b0;
         if (EN) begin
            case (fsm)
               S_IDLE: begin
                  if (accept) begin
                     char_q     <= CHAR_IN;
                     work_state <= cur_state;
                     fail_cnt   <= '0;
                     fsm        <= S_LOOKUP;
                  end
               end
               S_LOOKUP: fsm <= S_EVAL;
               S_EVAL: begin
                  if (hit) begin
                     cur_state <= TBL_NEXT;
                     if (match_commit) begin
                        match_valid_q <= 1'b1;
                        match_state_q <= TBL_NEXT;
                     end
                     fsm <= S_IDLE;
                  end else if (work_state == '0) begin
                     cur_state <= '0;
                     fsm       <= S_IDLE;
                  end else if (last_hop) begin
                     cur_state  <= '0;
                     err_loop_q <= 1'b1;
                     fsm        <= S_IDLE;
                  end else begin
                     // Intermediate states stay private until the walk resolves.
                     work_state <= TBL_FAIL;
                     fail_cnt   <= fail_cnt + 8'd1;
                     fsm        <= S_LOOKUP;
                  end
               end
               default: fsm <= S_IDLE;
            endcase
         end
      end
   end

`ifdef AC_MATCH_COUNT_EN
   logic [15:0] match_count_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         match_count_q <= '0;
      end else if (match_commit && (match_count_q != 16'hFFFF)) begin
         match_count_q <= match_count_q + 16'd1;
      end
   end

   assign MATCH_COUNT = match_count_q;
`else
   assign MATCH_COUNT = '0;
`endif

endmodule

// File: doc/ac_match_sequencer.md
# ac_match_sequencer

Sequencer that drives the Aho-Corasick goto/failure table lookup for a stream of 4-bit characters. It accepts one character at a time over a valid/ready handshake and issues table reads at the current automaton state. It follows failure links until a goto hit or state 0, then commits the new state and flags accepting states. It sits between the text input stream and the single-ported state-table RAM, and is the only master of that RAM's read port.

## Interface
- STATE_W, 8: automaton state width; also table address width.
- CHAR_W, 4: character width.
- MAX_FAIL, 16: maximum failure-link hops per character, 1..255.
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable; low freezes all state, no new reads, CHAR_READY low.
- CLR  in  1  synchronous restart of automaton at state 0, between texts.
- CHAR_VALID  in  1  character available.
- CHAR_IN  in  CHAR_W  character.
- CHAR_READY  out  1  sequencer can accept a character (IDLE and EN).
- TBL_RD  out  1  table read strobe.
- TBL_ADDR  out  STATE_W  table row = state being examined.
- TBL_CHARA  in  CHAR_W  goto character of row; valid cycle after TBL_RD.
- TBL_NEXT  in  STATE_W  goto target of row; same timing.
- TBL_FAIL  in  STATE_W  failure target of row; same timing.
- TBL_ACCEPT  in  1  TBL_NEXT is an accepting state; same timing.
- CUR_STATE  out  STATE_W  committed automaton state.
- BUSY  out  1  character in flight (LOOKUP or EVAL).
- MATCH_VALID  out  1  one-cycle pulse: committed state is accepting.
- MATCH_STATE  out  STATE_W  accepting state; held until next MATCH_VALID.
- ERR_LOOP  out  1  sticky: failure chain exceeded MAX_FAIL; cleared by RST only.
- MATCH_COUNT  out  16  number of MATCH_VALID pulses.

## Operation
- FSM states: IDLE, LOOKUP, EVAL.
- IDLE: CHAR_READY = EN. On CHAR_VALID & CHAR_READY, latch CHAR_IN, load work state from CUR_STATE, clear fail counter, go to LOOKUP.
- LOOKUP: TBL_RD=1, TBL_ADDR=work state. Go to EVAL.
- EVAL, compare TBL_CHARA against the latched character:
  - Hit: CUR_STATE<=TBL_NEXT. If TBL_ACCEPT, pulse MATCH_VALID next cycle with MATCH_STATE=TBL_NEXT. Go to IDLE.
  - Miss and work state==0: CUR_STATE<=0. Go to IDLE.
  - Miss and fail counter+1 == MAX_FAIL: CUR_STATE<=0, set ERR_LOOP. Go to IDLE.
  - Otherwise: work state<=TBL_FAIL, fail counter++. Go to LOOKUP.
- A miss at a non-zero state never commits an intermediate state to CUR_STATE.
- EN low in any state: all registers hold, TBL_RD=0.
  - A read issued in LOOKUP stays valid on the table outputs; the RAM holds its output while TBL_RD is low.
  - EVAL resumes when EN returns.
- CLR (EN-independent): FSM to IDLE, CUR_STATE and work state to 0, in-flight character dropped, MATCH_VALID=0. MATCH_STATE, ERR_LOOP and MATCH_COUNT keep their values.
- Priority: RST > CLR > EN.
- Handshake: CHAR_IN is sampled only in the accept cycle; no new character is accepted until FSM returns to IDLE.

## Timing
- Reset values:
  - FSM=IDLE, CUR_STATE=0.
  - CHAR_READY=0 during RST, then =EN.
  - TBL_RD=0, TBL_ADDR=0, BUSY=0.
  - MATCH_VALID=0, MATCH_STATE=0, ERR_LOOP=0, MATCH_COUNT=0.
- Table read latency is 1 cycle: TBL_RD in cycle T, table data valid in T+1.
- Hit on first row: accept in cycle T, TBL_RD in T+1, EVAL in T+2. CUR_STATE and MATCH_VALID are updated in T+3, and CHAR_READY is high again in T+3. Throughput is 3 cycles per character.
- Each failure hop adds 2 cycles. Worst case per character is 1+2·MAX_FAIL cycles with EN high.
- BUSY=1 exactly in LOOKUP and EVAL.
- RST or CLR asserted during LOOKUP/EVAL takes effect next cycle. No TBL_RD is issued in the cycle after.

## Configuration
- AC_MATCH_COUNT_EN defined: MATCH_COUNT increments on each MATCH_VALID pulse and saturates at 0xFFFF. It is cleared only by RST.
- Not defined: MATCH_COUNT tied to 0, and no counter logic is present.

## Test plan
Table rows (CHARA, NEXT, FAIL, ACCEPT): row0 = (0xA, 1, 0, 0), row1 = (0xB, 2, 0, 1), row2 = (0xA, 1, 1, 0).
- Feed 0xA, 0xB with EN=1 → CUR_STATE goes 1 then 2. MATCH_VALID pulses once, 3 cycles after 0xB is accepted, with MATCH_STATE=2. MATCH_COUNT=1 with the macro defined, 0 without.
- In state 2, feed 0xC → reads at address 2, then 1, then 0; CUR_STATE=0; no match; CHAR_READY low for exactly 6 cycles after accept.
- Set MAX_FAIL=1 and row1.FAIL=1 (self-loop); in state 1, feed 0x5 → CUR_STATE=0, ERR_LOOP=1 and sticky until RST.
- Drop EN for 4 cycles during EVAL of 0xA → TBL_RD stays low and state holds; after EN returns, CUR_STATE=1. Total latency is 3+4 cycles.
- Assert CLR during LOOKUP → next cycle FSM is IDLE, CUR_STATE=0, and no MATCH_VALID; MATCH_COUNT is unchanged.
- Assert RST for 1 cycle mid-EVAL → every output returns to its reset value the next cycle.
